// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the core run controller.
package cpu_run_ctrl_pkg;

  // Controller state encoding
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESETTING = 3'd1,
    ST_RUN       = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_STEP      = 3'd4,
    ST_HALTED    = 3'd5
  } run_state_t;

  // Halt cause codes reported on the cause output
  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_CORE    = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
  localparam logic [1:0] CAUSE_STOP    = 2'd3;

  // A run is in progress in every state between start and halt
  function automatic logic state_busy(input run_state_t s);
    logic b;
    case (s)
      ST_RESETTING: b = 1'b1;
      ST_RUN:       b = 1'b1;
      ST_PAUSE:     b = 1'b1;
      ST_STEP:      b = 1'b1;
      default:      b = 1'b0;
    endcase
    return b;
  endfunction

  // The core executes only in free-run and single-step states
  function automatic logic state_exec(input run_state_t s);
    logic e;
    case (s)
      ST_RUN:  e = 1'b1;
      ST_STEP: e = 1'b1;
      default: e = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat.sv
// Saturating up-counter with synchronous clear and a compare against LIMIT.
module sat_counter #(
  parameter int unsigned    W     = 32,
  parameter logic [W-1:0]   LIMIT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         at_limit
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

  logic [W-1:0] q_q;

  // Count enabled cycles, holding at all-ones; clear wins over enable
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= {W{1'b0}};
    end else if (clr) begin
      q_q <= {W{1'b0}};
    end else if (en && (q_q != MAX_VAL)) begin
      q_q <= q_q + W'(1);
    end else begin
      q_q <= q_q;
    end
  end

  assign q        = q_q;
  assign at_limit = (q_q == LIMIT);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: sequences core reset, free-run, single-step and halt,
// counts execute cycles and captures a0 when the run ends.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 3,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned MAX_CYCLES   = 50000,
  parameter int unsigned XLEN         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic             stop,
  input  logic             core_halt_req,
  input  logic [XLEN-1:0]  core_a0,
  output logic             core_rst,
  output logic             core_halt,
  output logic             busy,
  output logic             done,
  output logic [1:0]       cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [XLEN-1:0]  result
);

  localparam int unsigned    RW       = $clog2(RESET_CYCLES + 1);
  localparam logic [RW-1:0]  RC_LAST  = RW'(RESET_CYCLES - 1);
  localparam bit             TO_EN    = (MAX_CYCLES != 0);
  // Timeout fires on the execute cycle that sees MAX_CYCLES-1 already counted
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(MAX_CYCLES - 1);

  run_state_t      state_q, state_d;
  logic [RW-1:0]   rcnt_q, rcnt_d;

  logic            core_rst_q, core_rst_d;
  logic            core_halt_q, core_halt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [1:0]      cause_q, cause_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            exec_s;
  logic            start_run_s;
  logic            halt_s;
  logic [1:0]      trig_cause_s;
  logic            at_limit_s;
  logic            timeout_s;

  // Execute cycle: core is neither in reset nor halted, as seen on the pins
  assign exec_s    = ~core_rst_q & ~core_halt_q;
  assign timeout_s = TO_EN & at_limit_s;

  sat_counter #(
    .W     (CNT_W),
    .LIMIT (TO_LIMIT)
  ) u_cycle_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_run_s),
    .en       (exec_s),
    .q        (cycle_cnt),
    .at_limit (at_limit_s)
  );

  // State and reset-length counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rcnt_q  <= RW'(0);
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Next-state logic, including halt trigger detection and its cause
  always_comb begin
    state_d      = state_q;
    rcnt_d       = RW'(0);
    start_run_s  = 1'b0;
    halt_s       = 1'b0;
    trig_cause_s = CAUSE_NONE;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_d     = ST_RESETTING;
          start_run_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_RESETTING: begin
        if (stop) begin
          state_d      = ST_HALTED;
          halt_s       = 1'b1;
          trig_cause_s = CAUSE_STOP;
        end else if (rcnt_q == RC_LAST) begin
          state_d = step_mode ? ST_PAUSE : ST_RUN;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      ST_RUN, ST_STEP: begin
        if (exec_s && stop) begin
          state_d      = ST_HALTED;
          halt_s       = 1'b1;
          trig_cause_s = CAUSE_STOP;
        end else if (exec_s && core_halt_req) begin
          state_d      = ST_HALTED;
          halt_s       = 1'b1;
          trig_cause_s = CAUSE_CORE;
        end else if (exec_s && timeout_s) begin
          state_d      = ST_HALTED;
          halt_s       = 1'b1;
          trig_cause_s = CAUSE_TIMEOUT;
        end else if (state_q == ST_STEP) begin
          // A step grants exactly one execute cycle; a step pulse here is dropped
          state_d = ST_PAUSE;
        end else if (step_mode) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d      = ST_HALTED;
          halt_s       = 1'b1;
          trig_cause_s = CAUSE_STOP;
        end else if (step) begin
          state_d = ST_STEP;
        end else if (!step_mode) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output next values follow the upcoming state so pins line up with it
  always_comb begin
    core_rst_d  = (state_d == ST_IDLE) || (state_d == ST_RESETTING);
    core_halt_d = ~state_exec(state_d);
    busy_d      = state_busy(state_d);
    done_d      = (state_d == ST_HALTED);
    if (start_run_s) begin
      cause_d = CAUSE_NONE;
    end else if (halt_s) begin
      cause_d = trig_cause_s;
    end else begin
      cause_d = cause_q;
    end
    if (halt_s) begin
      result_d = core_a0;
    end else begin
      result_d = result_q;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      core_rst_q  <= 1'b1;
      core_halt_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cause_q     <= CAUSE_NONE;
      result_q    <= {XLEN{1'b0}};
    end else begin
      core_rst_q  <= core_rst_d;
      core_halt_q <= core_halt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cause_q     <= cause_d;
      result_q    <= result_d;
    end
  end

  assign core_rst  = core_rst_q;
  assign core_halt = core_halt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cause     = cause_q;
  assign result    = result_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl.
module tb_cpu_run_ctrl;

  logic        clk;
  logic        rst;
  logic        start, step_mode, step, stop, core_halt_req;
  logic [31:0] core_a0;
  logic        core_rst, core_halt, busy, done;
  logic [1:0]  cause;
  logic [31:0] cycle_cnt, result;

  // second instance: unlimited budget, 4-bit counter
  logic        start2;
  logic        zero2;
  logic [31:0] a0_2;
  logic        core_rst2, core_halt2, busy2, done2;
  logic [1:0]  cause2;
  logic [3:0]  cycle_cnt2;
  logic [31:0] result2;

  int n_checks = 0;
  int n_errors = 0;
  int n_exec;
  int n_low;

  cpu_run_ctrl #(.RESET_CYCLES(3), .CNT_W(32), .MAX_CYCLES(20), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
    .stop(stop), .core_halt_req(core_halt_req), .core_a0(core_a0),
    .core_rst(core_rst), .core_halt(core_halt), .busy(busy), .done(done),
    .cause(cause), .cycle_cnt(cycle_cnt), .result(result)
  );

  cpu_run_ctrl #(.RESET_CYCLES(3), .CNT_W(4), .MAX_CYCLES(0), .XLEN(32)) dut_sat (
    .clk(clk), .rst(rst), .start(start2), .step_mode(zero2), .step(zero2),
    .stop(zero2), .core_halt_req(zero2), .core_a0(a0_2),
    .core_rst(core_rst2), .core_halt(core_halt2), .busy(busy2), .done(done2),
    .cause(cause2), .cycle_cnt(cycle_cnt2), .result(result2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0; stop = 1'b0;
    core_halt_req = 1'b0; core_a0 = 32'h0;
    start2 = 1'b0; zero2 = 1'b0; a0_2 = 32'h0;
    cyc(2);
    check_eq("rst_core_rst",  32'(core_rst),  32'd1);
    check_eq("rst_core_halt", 32'(core_halt), 32'd1);
    check_eq("rst_busy",      32'(busy),      32'd0);
    check_eq("rst_done",      32'(done),      32'd0);
    check_eq("rst_cause",     32'(cause),     32'd0);
    check_eq("rst_cnt",       cycle_cnt,      32'd0);
    check_eq("rst_result",    result,         32'd0);
    rst = 1'b1;
    cyc(1);

    // core halt request on the 5th execute cycle
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check_eq("ch_rst_t1",  32'(core_rst), 32'd1);
    check_eq("ch_busy_t1", 32'(busy),     32'd1);
    cyc(2);
    check_eq("ch_rst_t3",  32'(core_rst),  32'd1);
    check_eq("ch_halt_t3", 32'(core_halt), 32'd1);
    cyc(1);
    check_eq("ch_rst_run",  32'(core_rst),  32'd0);
    check_eq("ch_halt_run", 32'(core_halt), 32'd0);
    cyc(4);
    check_eq("ch_cnt_pre", cycle_cnt, 32'd4);
    core_halt_req = 1'b1; core_a0 = 32'h2A;
    cyc(1);
    core_halt_req = 1'b0; core_a0 = 32'h0;
    check_eq("ch_cnt",    cycle_cnt,      32'd5);
    check_eq("ch_cause",  32'(cause),     32'd1);
    check_eq("ch_result", result,         32'h2A);
    check_eq("ch_done",   32'(done),      32'd1);
    check_eq("ch_halt",   32'(core_halt), 32'd1);
    check_eq("ch_busy",   32'(busy),      32'd0);
    check_eq("ch_corerst", 32'(core_rst), 32'd0);

    // timeout after exactly 20 execute cycles
    core_a0 = 32'h55;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check_eq("to_cnt_clr",   cycle_cnt,     32'd0);
    check_eq("to_cause_clr", 32'(cause),    32'd0);
    check_eq("to_done_clr",  32'(done),     32'd0);
    check_eq("to_core_rst",  32'(core_rst), 32'd1);
    n_exec = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      if (!core_rst && !core_halt) n_exec++;
      cyc(1);
    end
    check_eq("to_done",   32'(done),  32'd1);
    check_eq("to_nexec",  32'(n_exec), 32'd20);
    check_eq("to_cause",  32'(cause), 32'd2);
    check_eq("to_cnt",    cycle_cnt,  32'd20);
    check_eq("to_result", result,     32'h55);

    // synchronous reset in the middle of a run
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    cyc(10);
    check_eq("mr_cnt_pre", cycle_cnt, 32'd10);
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    check_eq("mr_core_rst",  32'(core_rst),  32'd1);
    check_eq("mr_core_halt", 32'(core_halt), 32'd1);
    check_eq("mr_busy",      32'(busy),      32'd0);
    check_eq("mr_done",      32'(done),      32'd0);
    check_eq("mr_cause",     32'(cause),     32'd0);
    check_eq("mr_cnt",       cycle_cnt,      32'd0);
    check_eq("mr_result",    result,         32'd0);
    cyc(2);
    check_eq("mr_idle_busy", 32'(busy),     32'd0);
    check_eq("mr_idle_rst",  32'(core_rst), 32'd1);

    // step mode: three steps plus one dropped back-to-back pulse
    step_mode = 1'b1;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    check_eq("st_pause_rst",  32'(core_rst),  32'd0);
    check_eq("st_pause_halt", 32'(core_halt), 32'd1);
    check_eq("st_pause_busy", 32'(busy),      32'd1);
    n_low = 0;
    for (int i = 0; i < 16; i++) begin
      step = (i == 0) || (i == 1) || (i == 4) || (i == 8);
      cyc(1);
      if (!core_halt) n_low++;
    end
    step = 1'b0;
    check_eq("st_nlow", 32'(n_low),      32'd3);
    check_eq("st_cnt",  cycle_cnt,       32'd3);
    check_eq("st_halt", 32'(core_halt),  32'd1);

    // stop and core request together: stop wins, result still captured
    step_mode = 1'b0;
    cyc(1);
    check_eq("pr_run_halt", 32'(core_halt), 32'd0);
    stop = 1'b1; core_halt_req = 1'b1; core_a0 = 32'h77;
    cyc(1);
    stop = 1'b0; core_halt_req = 1'b0;
    check_eq("pr_cause",  32'(cause), 32'd3);
    check_eq("pr_result", result,     32'h77);
    check_eq("pr_done",   32'(done),  32'd1);
    check_eq("pr_cnt",    cycle_cnt,  32'd4);

    // stop while the core is still held in reset
    core_a0 = 32'h99;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check_eq("sr_cause",    32'(cause),     32'd3);
    check_eq("sr_cnt",      cycle_cnt,      32'd0);
    check_eq("sr_done",     32'(done),      32'd1);
    check_eq("sr_busy",     32'(busy),      32'd0);
    check_eq("sr_core_rst", 32'(core_rst),  32'd0);
    check_eq("sr_halt",     32'(core_halt), 32'd1);
    check_eq("sr_result",   result,         32'h99);

    // unlimited budget with a 4-bit counter: saturate at 15, never time out
    start2 = 1'b1;
    cyc(1);
    start2 = 1'b0;
    cyc(3);
    check_eq("sat_run", 32'(core_halt2), 32'd0);
    cyc(20);
    check_eq("sat_cnt",   32'(cycle_cnt2), 32'd15);
    check_eq("sat_done",  32'(done2),      32'd0);
    check_eq("sat_busy",  32'(busy2),      32'd1);
    check_eq("sat_halt",  32'(core_halt2), 32'd0);
    check_eq("sat_cause", 32'(cause2),     32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Parametrised run controller that sequences reset, run, single-step and halt of a core such as `single_cycle_cpu`. It replaces fixed-delay stimulus with a synthesizable block that releases core reset after a programmable number of cycles, counts executed cycles, and halts the core on one of three causes: core request (ecall retire), cycle-budget timeout, or external stop. It also captures the core's `a0` at halt. It sits between the top-level/bench control inputs and the core's `rst`/`halt` pins.

## Interface
- `RESET_CYCLES`, default 3: cycles `core_rst` is held high after `start` (≥1)
- `CNT_W`, default 32: width of `cycle_cnt`
- `MAX_CYCLES`, default 50000: execute-cycle budget; 0 = unlimited
- `XLEN`, default 32: width of `core_a0`/`result`

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: **synchronous, active-low** reset
- `start` in 1: begin or restart a run (level sampled)
- `step_mode` in 1: 1 = pause between steps
- `step` in 1: one-cycle pulse; grants one execute cycle while paused
- `stop` in 1: external abort
- `core_halt_req` in 1: core signals completion this cycle
- `core_a0` in XLEN: core register a0
- `core_rst` out 1: active-high reset to core
- `core_halt` out 1: active-high halt to core
- `busy` out 1: run in progress
- `done` out 1: level, high in HALTED
- `cause` out 2: 0 none, 1 core request, 2 timeout, 3 external stop
- `cycle_cnt` out CNT_W: executed cycles of the current run
- `result` out XLEN: `core_a0` captured at halt

## Operation
- States: IDLE, RESETTING, RUN, PAUSE, STEP, HALTED. All outputs registered.
- Reset (`rst`=0 at a clock edge): state IDLE; `core_rst`=1, `core_halt`=1, `busy`=0, `done`=0, `cause`=0, `cycle_cnt`=0, `result`=0. Applies mid-run too and overrides everything.
- IDLE / HALTED + `start`=1: go to RESETTING; clear `cycle_cnt`, `cause`, `done`; `busy`=1.
- RESETTING: hold `core_rst`=1 and `core_halt`=1 for RESET_CYCLES cycles.
  - Then `core_rst`=0.
  - Go to PAUSE if `step_mode`=1, else RUN.
- RUN: `core_halt`=0. `step_mode`=1 moves to PAUSE next cycle.
- PAUSE: `core_halt`=1.
  - `step` pulse: go to STEP, with `core_halt`=0 for exactly one cycle, then back to PAUSE.
  - `step_mode`=0: go to RUN.
- Execute cycle: any cycle with `core_rst`=0 and `core_halt`=0.
  - `cycle_cnt` increments once per execute cycle.
  - `cycle_cnt` saturates at 2^CNT_W−1.
- Halt conditions are evaluated only on execute cycles. Priority: `stop` > `core_halt_req` > timeout.
  - Timeout: execute cycle with `cycle_cnt`==MAX_CYCLES−1 (MAX_CYCLES≠0).
  - `stop` is also honoured in PAUSE and RESETTING, with `cause`=3.
- Entering HALTED:
  - `core_halt`=1, `core_rst`=0, `busy`=0, `done`=1, `cause` set.
  - `result` ← `core_a0` sampled in the triggering cycle.
- `start` is ignored in RESETTING/RUN/PAUSE/STEP.
- `step` is ignored outside PAUSE.

## Timing
- `start` high at edge t: `core_rst`=1 on cycles t+1 … t+RESET_CYCLES.
  - `core_rst`=0 and `core_halt`=0 (free-run) from t+RESET_CYCLES+1.
- Trigger at execute cycle k: `core_halt`=1, `done`=1, `cause`, `result` valid at k+1.
  - The triggering cycle is counted in `cycle_cnt`.
- Timeout: exactly MAX_CYCLES execute cycles occur; final `cycle_cnt`=MAX_CYCLES.
- Step: `step` at edge s gives an execute cycle at s+1 and PAUSE again at s+2.
  - Back-to-back `step` pulses: the second pulse arriving in STEP is dropped.
- Simultaneous `stop` and `core_halt_req`: `cause`=3, and `result` is still captured.

## Structure
- Package `cpu_run_ctrl_pkg`:
  - state enum `run_state_t`
  - cause constants `CAUSE_NONE`, `CAUSE_CORE`, `CAUSE_TIMEOUT`, `CAUSE_STOP`
- One sub-module `sat_counter` (params `W`; ports `clr`, `en`, `q`, `at_limit` compare) used for `cycle_cnt`.
- The reset-length counter is local: width $clog2(RESET_CYCLES+1).

## Test plan
- Reset mid-run: after 10 execute cycles drive `rst`=0 for 1 cycle → all outputs at reset values the next cycle; state IDLE.
- Core halt: RESET_CYCLES=3, `start` at cycle 0, `core_halt_req` on the 5th execute cycle with `core_a0`=0x2A → `cycle_cnt`=5, `cause`=1, `result`=0x2A, `done`=1, `core_halt`=1.
- Timeout: MAX_CYCLES=20, no request → exactly 20 execute cycles, `cause`=2, `cycle_cnt`=20; then `start` again → counter cleared and a new reset sequence starts.
- Step mode: `step_mode`=1, three `step` pulses spaced 4 cycles apart → `core_halt` low for exactly 3 single cycles, `cycle_cnt`=3; an extra `step` in STEP is dropped.
- Priority: `stop` and `core_halt_req` in the same execute cycle → `cause`=3; `stop` during RESETTING → HALTED with `cycle_cnt`=0.
- Unlimited and saturation: MAX_CYCLES=0, CNT_W=4, run 20 execute cycles → no timeout, `cycle_cnt` holds at 15.
